// File: rtl/moore_seq_detector.sv
// Moore sequence detector with KMP-style fallback; the transition table is built at elaboration.
// Define SEQ_DET_COUNT_EN to add the saturating det_count output and its counter.
module moore_seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       x_in,
  input  logic       x_valid,
  input  logic       clear,
  output logic [3:0] y_out,
  output logic       detect
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [7:0] det_count
`endif
);

  typedef logic [3:0] state_t;

  localparam state_t FULL = state_t'(N);

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  function automatic state_t longest_match(input int k, input logic b);
    int pat;
    int seq;
    int len;
    pat = int'(PATTERN);
    seq = ((pat >> (N - k)) << 1) | int'(b);
    len = (k + 1 > N) ? N : k + 1;
    for (int j = len; j >= 1; j--) begin
      if ((seq & ((1 << j) - 1)) == (pat >> (N - j)))
        return state_t'(j);
    end
    return '0;
  endfunction

  function automatic logic [2*(N+1)*4-1:0] build_table();
    logic [2*(N+1)*4-1:0] tbl;
    int src;
    tbl = '0;
    for (int k = 0; k <= N; k++) begin
      src = (k == N && !OVERLAP) ? 0 : k;
      for (int b = 0; b < 2; b++)
        tbl[(2*k + b)*4 +: 4] = longest_match(src, b[0]);
    end
    return tbl;
  endfunction

  localparam logic [2*(N+1)*4-1:0] NEXT_TABLE = build_table();

  state_t state;
  state_t state_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= '0;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)
      state_next = '0;
    else if (x_valid)
      state_next = NEXT_TABLE[(2*int'(state) + int'(x_in))*4 +: 4];
  end

  always_comb begin
    y_out  = state;
    detect = (state == FULL);
  end

`ifdef SEQ_DET_COUNT_EN
  // A hit is entering SN, or a valid bit re-entering SN (only possible with overlap).
  logic count_hit;
  assign count_hit = (state_next == FULL) && ((state != FULL) || x_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      det_count <= '0;
    else if (clear)
      det_count <= '0;
    else if (count_hit && det_count != 8'hFF)
      det_count <= det_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: overlap, non-overlap and 2-bit saturation instances.
// Directed spec vectors followed by a random stream checked against a history-based model.
module tb_moore_seq_detector;

  localparam int         N   = 4;
  localparam logic [3:0] PAT = 4'b1011;

  typedef struct {
    string      tag;
    int         which;
    logic [7:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       clock = 1'b0;
  logic       reset, x_in, x_valid, clear;
  logic       s_x, s_valid, s_clear;
  logic [3:0] y_ov, y_nov, y_sat;
  logic       det_ov, det_nov, det_sat;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_ov, cnt_nov, cnt_sat;
`endif

  int ov_bits [7] = '{1, 0, 1, 1, 0, 1, 1};
  int ov_y    [7] = '{1, 2, 3, 4, 2, 3, 4};
  int nov_y   [7] = '{1, 2, 3, 4, 0, 1, 1};
  int gap_bits[4] = '{1, 0, 1, 1};

  always #5 clock = ~clock;

  moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_ov (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .y_out(y_ov), .detect(det_ov)
`ifdef SEQ_DET_COUNT_EN
    , .det_count(cnt_ov)
`endif
  );

  moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_nov (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .y_out(y_nov), .detect(det_nov)
`ifdef SEQ_DET_COUNT_EN
    , .det_count(cnt_nov)
`endif
  );

  moore_seq_detector #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .x_in(s_x), .x_valid(s_valid), .clear(s_clear),
    .y_out(y_sat), .detect(det_sat)
`ifdef SEQ_DET_COUNT_EN
    , .det_count(cnt_sat)
`endif
  );

  function automatic logic [7:0] observe(input int which);
    case (which)
      0: return {4'b0, y_ov};
      1: return {7'b0, det_ov};
      2: return {4'b0, y_nov};
      3: return {7'b0, det_nov};
      4: return {4'b0, y_sat};
      5: return {7'b0, det_sat};
`ifdef SEQ_DET_COUNT_EN
      6: return cnt_ov;
      7: return cnt_nov;
      8: return cnt_sat;
`endif
      default: return 8'hxx;
    endcase
  endfunction

  // Longest pattern prefix equal to the tail of the consumed-bit history.
  function automatic int model_state(input int h, input int l);
    for (int j = (l < N ? l : N); j >= 1; j--) begin
      if ((h & ((1 << j) - 1)) == int'(PAT >> (N - j)))
        return j;
    end
    return 0;
  endfunction

  task automatic expect_val(input string tag, input int which, input logic [7:0] value);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.which);
      n_checks++;
      assert (obs === e.value) else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input string tag, input logic b, input logic v, input logic c,
                                input int ey_ov, input int ey_nov);
    x_in    = b;
    x_valid = v;
    clear   = c;
    expect_val({tag, "_y_ov"},  0, 8'(ey_ov));
    expect_val({tag, "_d_ov"},  1, {7'b0, ey_ov == N});
    expect_val({tag, "_y_nov"}, 2, 8'(ey_nov));
    expect_val({tag, "_d_nov"}, 3, {7'b0, ey_nov == N});
    tick();
  endtask

  initial begin
    int h_ov, l_ov, h_nov, l_nov, e_ov, e_nov;
    logic b, v;

    reset = 1'b0; x_in = 1'b0; x_valid = 1'b0; clear = 1'b0;
    s_x = 1'b0; s_valid = 1'b0; s_clear = 1'b0;
    #12;
    expect_val("rst_y_ov", 0, 8'd0);
    expect_val("rst_d_ov", 1, 8'd0);
    expect_val("rst_y_nov", 2, 8'd0);
    expect_val("rst_y_sat", 4, 8'd0);
`ifdef SEQ_DET_COUNT_EN
    expect_val("rst_cnt_ov", 6, 8'd0);
`endif
    check_output();
    reset = 1'b1;
    apply_stimulus("idle_after_rst", 1'b1, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 7; i++) begin
`ifdef SEQ_DET_COUNT_EN
      if (i == 6) begin
        expect_val("stream_cnt_ov", 6, 8'd2);
        expect_val("stream_cnt_nov", 7, 8'd1);
      end
`endif
      apply_stimulus($sformatf("stream_b%0d", i + 1), 1'(ov_bits[i]), 1'b1, 1'b0,
                     ov_y[i], nov_y[i]);
    end
    apply_stimulus("clear_idle", 1'b1, 1'b0, 1'b1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus($sformatf("gap_b%0d", i + 1), 1'(gap_bits[i]), 1'b1, 1'b0, i + 1, i + 1);
      for (int g = 0; g < (i < 3 ? 3 : 2); g++) begin
`ifdef SEQ_DET_COUNT_EN
        if (i == 3) expect_val("gap_cnt_ov", 6, 8'd1);
`endif
        apply_stimulus($sformatf("gap_hold%0d_%0d", i + 1, g), ~1'(gap_bits[i]), 1'b0, 1'b0,
                       i + 1, i + 1);
      end
    end

    apply_stimulus("clrpri_pre0", 1'b0, 1'b1, 1'b0, 2, 0);
    apply_stimulus("clrpri_pre1", 1'b1, 1'b1, 1'b0, 3, 1);
`ifdef SEQ_DET_COUNT_EN
    expect_val("clrpri_cnt_ov", 6, 8'd0);
`endif
    apply_stimulus("clrpri", 1'b1, 1'b1, 1'b1, 0, 0);

    apply_stimulus("mid_b1", 1'b1, 1'b1, 1'b0, 1, 1);
    apply_stimulus("mid_b2", 1'b0, 1'b1, 1'b0, 2, 2);
    apply_stimulus("mid_b3", 1'b1, 1'b1, 1'b0, 3, 3);
    #3 reset = 1'b0;
    #1;
    expect_val("async_rst_y_ov", 0, 8'd0);
    expect_val("async_rst_d_ov", 1, 8'd0);
    expect_val("async_rst_y_nov", 2, 8'd0);
    check_output();
    #2 reset = 1'b1;
    apply_stimulus("post_rst", 1'b1, 1'b1, 1'b0, 1, 1);

    apply_stimulus("kmp_a", 1'b0, 1'b1, 1'b0, 2, 2);
    apply_stimulus("kmp_b", 1'b1, 1'b1, 1'b0, 3, 3);
    apply_stimulus("kmp_fallback", 1'b0, 1'b1, 1'b0, 2, 2);
    apply_stimulus("kmp_c", 1'b1, 1'b1, 1'b0, 3, 3);
    apply_stimulus("kmp_d", 1'b1, 1'b1, 1'b0, 4, 4);
    apply_stimulus("kmp_after_full", 1'b1, 1'b1, 1'b0, 1, 1);

    x_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      s_x = 1'b1;
      s_valid = 1'b1;
      expect_val($sformatf("sat_y_%0d", i), 4, (i == 1) ? 8'd1 : 8'd2);
      expect_val($sformatf("sat_d_%0d", i), 5, (i == 1) ? 8'd0 : 8'd1);
`ifdef SEQ_DET_COUNT_EN
      expect_val($sformatf("sat_cnt_%0d", i), 8, (i - 1 > 255) ? 8'd255 : 8'(i - 1));
`endif
      tick();
    end
    s_valid = 1'b0;

    apply_stimulus("rand_clear", 1'b0, 1'b0, 1'b1, 0, 0);
    h_ov = 0; l_ov = 0; h_nov = 0; l_nov = 0; e_ov = 0; e_nov = 0;
    for (int i = 0; i < 80; i++) begin
      b = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        if (e_nov == N) begin
          h_nov = 0;
          l_nov = 0;
        end
        h_ov  = ((h_ov << 1) | int'(b)) & 32'hF;
        h_nov = ((h_nov << 1) | int'(b)) & 32'hF;
        l_ov  = (l_ov < N) ? l_ov + 1 : N;
        l_nov = (l_nov < N) ? l_nov + 1 : N;
        e_ov  = model_state(h_ov, l_ov);
        e_nov = model_state(h_nov, l_nov);
      end
      apply_stimulus($sformatf("rand_%0d", i), b, v, 1'b0, e_ov, e_nov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
